sd_cmd_sequencer: RTL and testbench
===================================

# sd_cmd_sequencer

Sequences one SD-card SPI-mode command frame through the SPI_master register port: it writes the control register, pushes the six command bytes, then clocks 0xFF fill bytes until an R1 response arrives or the NCR limit expires. It sits between the SD controller's host-facing register logic and the SPI_master instance. It is the only agent driving the SPI_master's CS/WR/RD/addr lines. The top level converts its split data buses onto the SPI_master's bidirectional data_bus.

## Interface
- NCR_MAX, 8: maximum 0xFF fill bytes clocked while waiting for R1.
- POLL_MAX, 1023: maximum status polls per byte before declaring a byte timeout.
- GUARD, 2: idle cycles after a txdata write before the first status poll.
- pro_clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a command; sampled only in IDLE.
- cmd_index  in  6  SD command number.
- arg  in  32  command argument, sent MSB first.
- crc7  in  7  CRC7 for the final command byte.
- cfg_ctrl  in  8  SPI_master control value: [2:0] divider, [3] CPOL, [4] CPHA, [7:5] slave index.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of every command.
- r1  out  8  response byte; valid from done until the next start.
- err_ncr  out  1  no R1 response within NCR_MAX fill bytes; valid with done.
- err_poll  out  1  byte transfer never completed; valid with done.
- spi_cs, spi_wr, spi_rd  out  1  SPI_master access strobes.
- spi_addr  out  2  SPI_master register select.
- spi_wdata  out  8  write data to SPI_master.
- spi_rdata  in  8  SPI_master data_bus, as seen while spi_rd is high.

## Operation
- Frame bytes, in order:
  - B0 = {2'b01, cmd_index}
  - B1..B4 = arg[31:24] .. arg[7:0]
  - B5 = {crc7, 1'b1}
  - fill bytes = 8'hFF
- On start, latch cmd_index, arg, crc7 and cfg_ctrl. Clear r1, err_ncr and err_poll.
- State sequence:
  - IDLE -> CFG: write the control register once.
  - CFG -> LOAD: write txdata.
  - LOAD -> GUARD: hold for GUARD cycles.
  - GUARD -> POLL: read status. If bit0 = 0, repeat POLL; if bit0 = 1, go to RX.
  - RX: read rxdata, then go to NEXT.
  - NEXT: if command bytes remain, return to LOAD with the next byte. Otherwise send or evaluate fill bytes.
  - DONE: pulse done, return to IDLE.
- Fill phase:
  - The rxdata captured for B0..B5 is discarded.
  - A fill byte with rxdata[7] = 0 becomes r1 and ends the frame (go to DONE).
  - If NCR_MAX fill bytes all read rxdata[7] = 1: r1 = 8'hFF, err_ncr = 1, go to DONE.
- POLL timeout: when POLL_MAX consecutive polls all read bit0 = 0, set err_poll = 1, leave r1 = 8'hFF and go to DONE. No further bytes are sent.
- The poll counter resets on every LOAD.

## Timing
- Write access: exactly one cycle with spi_cs = spi_wr = 1 and spi_addr/spi_wdata valid, followed by one cycle with all strobes low.
- Read access: two cycles with spi_cs = spi_rd = 1 and spi_addr held. spi_rdata is sampled at the rising edge ending the second cycle; strobes drop afterwards.
- spi_wr and spi_rd are never high together. Outside accesses spi_cs = 0 and spi_addr = 0.
- Reset values: busy = 0, done = 0, r1 = 8'hFF, err_ncr = 0, err_poll = 0, all spi_* = 0, state = IDLE.
- Reset asserted mid-frame aborts immediately. No done pulse is produced. An in-flight SPI byte completes in the SPI_master and is ignored.
- start during busy or DONE is ignored. start in the same cycle that done is pulsed is ignored.
- Minimum pro_clk latency per byte = 1 (write) + 1 + GUARD + 3·(polls) + 3 (rx read) + 1 (NEXT), plus the SPI shift time.

## Structure
- Shared package sd_spi_pkg:
  - register addresses: REG_CTRL = 2'b00, REG_STATUS = 2'b01, REG_TX = 2'b10, REG_RX = 2'b11
  - the state enum
  - SD_CMD_START = 2'b01, FILL_BYTE = 8'hFF
- One sub-module, spi_reg_port:
  - accepts a req/we/addr/wdata request and performs the 1-cycle write or 2-cycle read
  - returns ack with rdata
  - the sequencer FSM issues requests only through it.

## Test plan
- CMD0, arg = 0, crc7 = 7'h4A; slave model returns R1 = 8'h01 on the 2nd fill byte -> MOSI bytes 40 00 00 00 00 95 FF FF; r1 = 8'h01; done pulses once; no error flags.
- CMD8, arg = 32'h000001AA -> B1..B4 observed as 00 00 01 AA; cfg_ctrl = 8'h23 is written to REG_CTRL before the first REG_TX write.
- Slave returns only 8'hFF -> exactly NCR_MAX (8) fill bytes are sent; err_ncr = 1; r1 = 8'hFF.
- SPI_master model never sets status bit0 -> after 1023 polls err_poll = 1; done pulses; busy falls the next cycle.
- rst_n pulsed low during the B3 transfer -> all outputs return to reset values asynchronously; the next start produces a clean frame.
- start held high for 5 cycles, and start asserted while busy -> exactly one frame is sent; strobe checker confirms spi_wr and spi_rd are never high together.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg
//   Shared definitions for the SD-card SPI-mode command sequencer and its
//   SPI_master register port: register map, frame constants, sequencer
//   state encoding and the frame byte selector.
package sd_spi_pkg;

   // SPI_master register map
   localparam logic [1:0] REG_CTRL   = 2'b00;
   localparam logic [1:0] REG_STATUS = 2'b01;
   localparam logic [1:0] REG_TX     = 2'b10;
   localparam logic [1:0] REG_RX     = 2'b11;

   // SD command framing
   localparam logic [1:0] SD_CMD_START = 2'b01;
   localparam logic [7:0] FILL_BYTE    = 8'hFF;

   // Byte index 0..5 are command bytes; index 6 stands for every fill byte.
   localparam logic [2:0] FILL_IDX = 3'd6;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_CFG   = 4'd1,
      ST_LOAD  = 4'd2,
      ST_GUARD = 4'd3,
      ST_POLL  = 4'd4,
      ST_RX    = 4'd5,
      ST_NEXT  = 4'd6,
      ST_DONE  = 4'd7
   } sd_state_e;

   // Byte sent on MOSI for a given frame position.
   function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                             input logic [5:0]  cmd_index,
                                             input logic [31:0] arg,
                                             input logic [6:0]  crc7);
      case (idx)
         3'd0:    frame_byte = {SD_CMD_START, cmd_index};
         3'd1:    frame_byte = arg[31:24];
         3'd2:    frame_byte = arg[23:16];
         3'd3:    frame_byte = arg[15:8];
         3'd4:    frame_byte = arg[7:0];
         3'd5:    frame_byte = {crc7, 1'b1};
         default: frame_byte = FILL_BYTE;
      endcase
   endfunction

endpackage

// File: rtl/spi_reg_port.sv
// spi_reg_port
//   Turns a level request (req/we/addr/wdata) into one SPI_master register
//   access. A write drives one strobe cycle followed by one idle cycle in
//   which ack is high. A read drives two strobe cycles, captures spi_rdata at
//   the edge ending the second, then raises ack for one idle cycle.
//   The requester must hold req/we/addr/wdata stable until it sees ack and
//   must move on in the ack cycle; req is ignored while ack is high.
// Ports:
//   pro_clk, rst_n        clock, asynchronous active-low reset
//   req, we, addr, wdata  access request from the sequencer
//   ack                   one-cycle completion, rdata valid with it
//   rdata                 last value read (held until the next read)
//   spi_cs/wr/rd/addr/wdata, spi_rdata   SPI_master register bus
module spi_reg_port (
   input  logic       pro_clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   output logic       ack,
   output logic [7:0] rdata,
   output logic       spi_cs,
   output logic       spi_wr,
   output logic       spi_rd,
   output logic [1:0] spi_addr,
   output logic [7:0] spi_wdata,
   input  logic [7:0] spi_rdata
);

   typedef enum logic [1:0] {
      P_IDLE = 2'd0,
      P_RD2  = 2'd1,
      P_ACK  = 2'd2
   } port_state_e;

   port_state_e pst;
   logic        strobe_on;
   logic        wr_on;

   always_ff @(posedge pro_clk or negedge rst_n) begin
      if (!rst_n) begin
         pst <= P_IDLE;
      end else begin
         case (pst)
            P_IDLE:  if (req) pst <= we ? P_ACK : P_RD2;
            P_RD2:   pst <= P_ACK;
            default: pst <= P_IDLE;
         endcase
      end
   end

   // Read data is captured at the edge that ends the second read cycle.
   always_ff @(posedge pro_clk) begin
      if (pst == P_RD2) rdata <= spi_rdata;
   end

   // The first strobe cycle coincides with the accepting cycle, so a write
   // costs two cycles and a read three, ack cycle included.
   assign strobe_on = ((pst == P_IDLE) && req) || (pst == P_RD2);
   assign wr_on     = (pst == P_IDLE) && req && we;

   assign spi_cs    = strobe_on;
   assign spi_wr    = wr_on;
   assign spi_rd    = strobe_on && !wr_on;
   assign spi_addr  = strobe_on ? addr : 2'b00;
   assign spi_wdata = wr_on ? wdata : 8'h00;
   assign ack       = (pst == P_ACK);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
//   Sends one SD SPI-mode command frame through the SPI_master register
//   port: control register write, six command bytes, then 0xFF fill bytes
//   until an R1 byte (bit7 = 0) arrives or NCR_MAX fills have been sent.
//   Each byte is: write txdata, wait GUARD cycles, poll status bit0, read
//   rxdata.
// Ports:
//   pro_clk, rst_n                  clock, asynchronous active-low reset
//   start                           begin a command (accepted only in IDLE)
//   cmd_index, arg, crc7, cfg_ctrl  command fields, latched on start
//   busy, done                      frame in progress / end-of-frame pulse
//   r1, err_ncr, err_poll           result, valid from done to next start
//   spi_cs/wr/rd/addr/wdata         SPI_master register strobes and data
//   spi_rdata                       SPI_master data as seen during reads
module sd_cmd_sequencer #(
   parameter int NCR_MAX  = 8,
   parameter int POLL_MAX = 1023,
   parameter int GUARD    = 2
) (
   input  logic        pro_clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] arg,
   input  logic [6:0]  crc7,
   input  logic [7:0]  cfg_ctrl,
   output logic        busy,
   output logic        done,
   output logic [7:0]  r1,
   output logic        err_ncr,
   output logic        err_poll,
   output logic        spi_cs,
   output logic        spi_wr,
   output logic        spi_rd,
   output logic [1:0]  spi_addr,
   output logic [7:0]  spi_wdata,
   input  logic [7:0]  spi_rdata
);
   import sd_spi_pkg::*;

   localparam int PW = $clog2(POLL_MAX + 1);
   localparam int FW = $clog2(NCR_MAX + 1);
   localparam int GW = $clog2(GUARD + 2);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
   localparam logic [FW-1:0] FILL_LAST = FW'(NCR_MAX - 1);

   sd_state_e     state;
   logic [2:0]    byte_idx;
   logic [FW-1:0] fill_cnt;
   logic [PW-1:0] poll_cnt;
   logic [GW-1:0] guard_cnt;
   logic          guard_done;

   logic [5:0]    cmd_q;
   logic [31:0]   arg_q;
   logic [6:0]    crc_q;
   logic [7:0]    cfg_q;

   logic          req;
   logic          we;
   logic [1:0]    addr;
   logic [7:0]    wdata;
   logic          ack;
   logic [7:0]    port_rdata;

   assign guard_done = (int'(guard_cnt) + 1 >= GUARD);

   // Command fields are plain data: captured on an accepted start only.
   always_ff @(posedge pro_clk) begin
      if ((state == ST_IDLE) && start) begin
         cmd_q <= cmd_index;
         arg_q <= arg;
         crc_q <= crc7;
         cfg_q <= cfg_ctrl;
      end
   end

   // Register-port request implied by the current state.
   always_comb begin
      req   = 1'b0;
      we    = 1'b0;
      addr  = REG_CTRL;
      wdata = 8'h00;
      case (state)
         ST_CFG: begin
            req   = 1'b1;
            we    = 1'b1;
            addr  = REG_CTRL;
            wdata = cfg_q;
         end
         ST_LOAD: begin
            req   = 1'b1;
            we    = 1'b1;
            addr  = REG_TX;
            wdata = frame_byte(byte_idx, cmd_q, arg_q, crc_q);
         end
         ST_POLL: begin
            req  = 1'b1;
            addr = REG_STATUS;
         end
         ST_RX: begin
            req  = 1'b1;
            addr = REG_RX;
         end
         default: ;
      endcase
   end

   always_ff @(posedge pro_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         r1        <= FILL_BYTE;
         err_ncr   <= 1'b0;
         err_poll  <= 1'b0;
         byte_idx  <= 3'd0;
         fill_cnt  <= '0;
         poll_cnt  <= '0;
         guard_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_CFG;
                  busy     <= 1'b1;
                  r1       <= FILL_BYTE;
                  err_ncr  <= 1'b0;
                  err_poll <= 1'b0;
                  byte_idx <= 3'd0;
                  fill_cnt <= '0;
               end
            end
            ST_CFG: begin
               if (ack) state <= ST_LOAD;
            end
            ST_LOAD: begin
               if (ack) begin
                  state     <= ST_GUARD;
                  guard_cnt <= '0;
                  poll_cnt  <= '0;
               end
            end
            ST_GUARD: begin
               if (guard_done) state <= ST_POLL;
               else            guard_cnt <= guard_cnt + 1'b1;
            end
            ST_POLL: begin
               if (ack) begin
                  if (port_rdata[0]) begin
                     state <= ST_RX;
                  end else if (poll_cnt == POLL_LAST) begin
                     // Byte never completed: abandon the frame, r1 stays 0xFF.
                     err_poll <= 1'b1;
                     done     <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     poll_cnt <= poll_cnt + 1'b1;
                  end
               end
            end
            ST_RX: begin
               if (ack) state <= ST_NEXT;
            end
            ST_NEXT: begin
               // port_rdata still holds the rxdata just read.
               if (byte_idx != FILL_IDX) begin
                  byte_idx <= byte_idx + 3'd1;
                  state    <= ST_LOAD;
               end else if (!port_rdata[7]) begin
                  r1    <= port_rdata;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (fill_cnt == FILL_LAST) begin
                  err_ncr <= 1'b1;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  fill_cnt <= fill_cnt + 1'b1;
                  state    <= ST_LOAD;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   spi_reg_port u_port (
      .pro_clk   (pro_clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .ack       (ack),
      .rdata     (port_rdata),
      .spi_cs    (spi_cs),
      .spi_wr    (spi_wr),
      .spi_rd    (spi_rd),
      .spi_addr  (spi_addr),
      .spi_wdata (spi_wdata),
      .spi_rdata (spi_rdata)
   );

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer
//   Drives sd_cmd_sequencer against a behavioural SPI_master + SD slave
//   model and compares each frame with a reference built from the SD frame
//   rules (command bytes, fill-until-R1, NCR and poll limits).
module tb_sd_cmd_sequencer;

   localparam int NCR_MAX  = 8;
   localparam int POLL_MAX = 1023;
   localparam int GUARD    = 2;

   logic        pro_clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [5:0]  cmd_index;
   logic [31:0] arg;
   logic [6:0]  crc7;
   logic [7:0]  cfg_ctrl;
   logic        busy, done, err_ncr, err_poll;
   logic [7:0]  r1;
   logic        spi_cs, spi_wr, spi_rd;
   logic [1:0]  spi_addr;
   logic [7:0]  spi_wdata, spi_rdata;

   always #5 pro_clk = ~pro_clk;

   sd_cmd_sequencer #(.NCR_MAX(NCR_MAX), .POLL_MAX(POLL_MAX), .GUARD(GUARD)) dut (
      .pro_clk(pro_clk), .rst_n(rst_n), .start(start), .cmd_index(cmd_index),
      .arg(arg), .crc7(crc7), .cfg_ctrl(cfg_ctrl), .busy(busy), .done(done),
      .r1(r1), .err_ncr(err_ncr), .err_poll(err_poll), .spi_cs(spi_cs),
      .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_addr(spi_addr),
      .spi_wdata(spi_wdata), .spi_rdata(spi_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- SPI_master + SD slave model ----------------
   logic [7:0] fill_resp [NCR_MAX];
   logic       never_ready = 1'b0;
   int         frame_base  = 0;

   logic [7:0] tx_log[$];
   logic [7:0] ctrl_log[$];
   logic [1:0] wr_addr_log[$];

   logic [7:0] m_ctrl    = 8'h00;
   logic [7:0] m_rx      = 8'hFF;
   logic [7:0] m_rx_next = 8'hFF;
   logic       m_ready   = 1'b0;
   logic       m_pending = 1'b0;
   int         m_delay   = 0;

   function automatic logic [7:0] resp_for(input int idx);
      if (idx < 6)                resp_for = 8'($urandom_range(0, 255));
      else if (idx - 6 < NCR_MAX) resp_for = fill_resp[idx - 6];
      else                        resp_for = 8'hFF;
   endfunction

   assign spi_rdata = !spi_rd             ? 8'h00 :
                      (spi_addr == 2'b01) ? {7'd0, m_ready} :
                      (spi_addr == 2'b11) ? m_rx : m_ctrl;

   always @(negedge pro_clk) begin
      if (spi_cs && spi_wr) begin
         wr_addr_log.push_back(spi_addr);
         if (spi_addr == 2'b00) begin
            ctrl_log.push_back(spi_wdata);
            m_ctrl <= spi_wdata;
         end
         if (spi_addr == 2'b10) begin
            m_rx_next <= resp_for(tx_log.size() - frame_base);
            tx_log.push_back(spi_wdata);
            m_ready   <= 1'b0;
            m_pending <= 1'b1;
            m_delay   <= int'($urandom_range(0, 6));
         end
      end else if (m_pending) begin
         if (m_delay == 0) begin
            m_pending <= 1'b0;
            m_ready   <= !never_ready;
            m_rx      <= m_rx_next;
         end else begin
            m_delay <= m_delay - 1;
         end
      end
   end

   // ---------------- bus monitor ----------------
   int   done_cnt = 0;
   int   stat_rd_cycles = 0;
   int   strobe_viol = 0;
   int   rd_run = 0;
   logic wr_prev = 1'b0;

   always @(negedge pro_clk) begin
      if (done) done_cnt++;
      if (spi_cs && spi_rd && spi_addr == 2'b01) stat_rd_cycles++;
      if (spi_wr && spi_rd) strobe_viol++;
      if (!spi_cs && (spi_wr || spi_rd || spi_addr != 2'b00)) strobe_viol++;
      if (spi_wr && wr_prev) strobe_viol++;
      if (!rst_n) rd_run = 0;
      else if (spi_rd) rd_run++;
      else begin
         if (rd_run != 0 && rd_run != 2) strobe_viol++;
         rd_run = 0;
      end
      wr_prev = spi_wr;
   end

   // ---------------- one frame against the reference ----------------
   task automatic run_frame(input string name, input int hold, input bit poke, input bit start_in_done);
      logic [7:0] exp_q[$];
      logic [7:0] er1;
      logic       encr, epoll;
      int         base_done, base_stat, base_wr, base_ctrl;
      bit         got;
      logic [31:0] obs;

      exp_q.push_back({2'b01, cmd_index});
      er1 = 8'hFF; encr = 1'b0; epoll = 1'b0;
      if (never_ready) begin
         epoll = 1'b1;
      end else begin
         for (int i = 3; i >= 0; i--) exp_q.push_back(arg[8*i +: 8]);
         exp_q.push_back({crc7, 1'b1});
         encr = 1'b1;
         for (int k = 0; k < NCR_MAX; k++) begin
            exp_q.push_back(8'hFF);
            if (!fill_resp[k][7]) begin
               er1 = fill_resp[k];
               encr = 1'b0;
               break;
            end
         end
      end

      base_done  = done_cnt;
      base_stat  = stat_rd_cycles;
      base_wr    = wr_addr_log.size();
      base_ctrl  = ctrl_log.size();
      frame_base = tx_log.size();

      @(negedge pro_clk);
      start = 1'b1;
      repeat (hold) @(negedge pro_clk);
      start = 1'b0;
      check({name, "_busy"}, 32'(busy), 32'd1);

      got = 1'b0;
      for (int c = 0; c < 20000 && !got; c++) begin
         if (poke && c == 40) start = 1'b1;
         if (poke && c == 41) start = 1'b0;
         @(negedge pro_clk);
         if (done) got = 1'b1;
      end
      check({name, "_done_seen"}, 32'(got), 32'd1);
      check({name, "_r1"}, 32'(r1), 32'(er1));
      check({name, "_err_ncr"}, 32'(err_ncr), 32'(encr));
      check({name, "_err_poll"}, 32'(err_poll), 32'(epoll));

      if (start_in_done) start = 1'b1;
      @(negedge pro_clk);
      start = 1'b0;
      check({name, "_busy_fall"}, 32'(busy), 32'd0);
      check({name, "_done_once"}, 32'(done_cnt - base_done), 32'd1);

      check({name, "_byte_count"}, 32'(tx_log.size() - frame_base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (frame_base + i < tx_log.size()) ? 32'(tx_log[frame_base + i]) : 32'hDEAD;
         check($sformatf("%s_byte%0d", name, i), obs, 32'(exp_q[i]));
      end

      check({name, "_ctrl_writes"}, 32'(ctrl_log.size() - base_ctrl), 32'd1);
      obs = (base_ctrl < ctrl_log.size()) ? 32'(ctrl_log[base_ctrl]) : 32'hDEAD;
      check({name, "_ctrl_value"}, obs, 32'(cfg_ctrl));
      obs = (base_wr < wr_addr_log.size()) ? 32'(wr_addr_log[base_wr]) : 32'hDEAD;
      check({name, "_ctrl_first"}, obs, 32'd0);

      if (never_ready)
         check({name, "_poll_count"}, 32'((stat_rd_cycles - base_stat) / 2), 32'(POLL_MAX));

      if (start_in_done) begin
         repeat (3) @(negedge pro_clk);
         check({name, "_start_in_done_ignored"}, 32'({busy, spi_cs}), 32'd0);
      end
   endtask

   task automatic set_fields(input logic [5:0] ci, input logic [31:0] a, input logic [6:0] c, input logic [7:0] cfg);
      cmd_index = ci; arg = a; crc7 = c; cfg_ctrl = cfg;
   endtask

   task automatic fill_all(input logic [7:0] v);
      for (int k = 0; k < NCR_MAX; k++) fill_resp[k] = v;
   endtask

   task automatic fill_random();
      for (int k = 0; k < NCR_MAX; k++)
         fill_resp[k] = ($urandom_range(0, 9) < 7) ? (8'h80 | 8'($urandom_range(0, 255)))
                                                   : (8'h7F & 8'($urandom_range(0, 255)));
   endtask

   initial begin
      bit reached;
      int base_done;

      rst_n = 1'b0; start = 1'b0;
      set_fields(6'd0, 32'd0, 7'd0, 8'd0);
      fill_all(8'hFF);
      repeat (3) @(negedge pro_clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_r1", 32'(r1), 32'hFF);
      check("rst_errs", 32'({err_ncr, err_poll}), 32'd0);
      check("rst_spi", 32'({spi_cs, spi_wr, spi_rd, spi_addr, spi_wdata}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge pro_clk);

      // CMD0, R1 = 0x01 on the second fill byte
      set_fields(6'd0, 32'd0, 7'h4A, 8'h05);
      fill_all(8'hFF); fill_resp[1] = 8'h01;
      run_frame("cmd0", 1, 1'b0, 1'b0);

      // CMD8 with cfg 0x23
      set_fields(6'd8, 32'h000001AA, 7'h43, 8'h23);
      fill_all(8'hFF); fill_resp[0] = 8'h01;
      run_frame("cmd8", 1, 1'b0, 1'b0);

      // No response at all
      set_fields(6'd17, 32'h12345678, 7'h2B, 8'h11);
      fill_all(8'hFF);
      run_frame("ncr", 1, 1'b0, 1'b0);

      // Randomized frames
      for (int n = 0; n < 4; n++) begin
         set_fields(6'($urandom_range(0, 63)), $urandom, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
         fill_random();
         run_frame($sformatf("rand%0d", n), 1, 1'b0, 1'b0);
      end

      // Status bit0 never sets
      never_ready = 1'b1;
      set_fields(6'd55, 32'hCAFEF00D, 7'h11, 8'h07);
      run_frame("polltmo", 1, 1'b0, 1'b0);
      never_ready = 1'b0;

      // Reset in the middle of the B3 transfer
      set_fields(6'd24, 32'hA1B2C3D4, 7'h5E, 8'h42);
      fill_random();
      base_done  = done_cnt;
      frame_base = tx_log.size();
      @(negedge pro_clk); start = 1'b1;
      @(negedge pro_clk); start = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 5000 && !reached; c++) begin
         @(negedge pro_clk);
         if (tx_log.size() - frame_base >= 4 && spi_rd) reached = 1'b1;
      end
      check("midrst_reached_b3_read", 32'(reached), 32'd1);
      check("midrst_busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_r1", 32'(r1), 32'hFF);
      check("midrst_errs", 32'({err_ncr, err_poll}), 32'd0);
      check("midrst_spi", 32'({spi_cs, spi_wr, spi_rd, spi_addr, spi_wdata}), 32'd0);
      repeat (3) @(negedge pro_clk);
      rst_n = 1'b1;
      repeat (10) @(negedge pro_clk);
      check("midrst_no_done", 32'(done_cnt - base_done), 32'd0);
      set_fields(6'd9, 32'h0F0F0F0F, 7'h33, 8'h3C);
      fill_random();
      run_frame("after_rst", 1, 1'b0, 1'b0);

      // start held for 5 cycles, poked while busy, and raised during done
      set_fields(6'd41, 32'h40300000, 7'h77, 8'h1A);
      fill_random();
      run_frame("hold5", 5, 1'b1, 1'b1);

      check("strobe_protocol", 32'(strobe_viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
